// File: rtl/lfsr_multistep.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_multistep
// Description : Parametrised Fibonacci/Galois LFSR advancing up to MAX_STEP
//               steps per cycle, with lock-up detection, optional recovery,
//               saturating step counter and seed-return pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_multistep #(
    parameter int               WIDTH        = 16,
    parameter int               MAX_STEP     = 4,
    parameter logic [WIDTH-1:0] RESET_STATE  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               AUTO_RECOVER = 0,
    parameter int               CNT_W        = 32,
    localparam int              SC_W         = $clog2(MAX_STEP + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reinit,
    input  logic                advance,
    input  logic [SC_W-1:0]     step_count,
    input  logic                galois,
    input  logic [WIDTH-1:0]    initial_state,
    input  logic [WIDTH-1:0]    taps,
    output logic [WIDTH-1:0]    out_state,
    output logic [MAX_STEP-1:0] out_bits,
    output logic                out_valid,
    output logic                lockup,
    output logic                seed_hit,
    output logic [CNT_W-1:0]    step_cnt
);

    localparam logic [SC_W-1:0]  c_MAX_N    = SC_W'(MAX_STEP);
    localparam logic [WIDTH-1:0] c_RECOVER  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    r_state;
    logic [WIDTH-1:0]    r_seed;
    logic [MAX_STEP-1:0] r_bits;
    logic                r_valid;
    logic                r_hit;
    logic [CNT_W-1:0]    r_cnt;

    logic [SC_W-1:0]     w_n;
    logic [WIDTH-1:0]    w_chain [0:MAX_STEP];
    logic [WIDTH-1:0]    w_next;
    logic [MAX_STEP-1:0] w_bits;
    logic [CNT_W:0]      w_sum;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_recover;

    assign w_n        = (step_count > c_MAX_N) ? c_MAX_N : step_count;
    assign w_chain[0] = r_state;

    // Chain of MAX_STEP single-step stages; stage k+1 is the state after k+1 steps.
    generate
        for (genvar k = 0; k < MAX_STEP; k++) begin : g_step
            localparam logic [SC_W-1:0] c_K = SC_W'(k);
            assign w_chain[k+1] = galois
                ? ({w_chain[k][WIDTH-2:0], 1'b0} ^ (w_chain[k][WIDTH-1] ? taps : '0))
                : {w_chain[k][WIDTH-2:0], ^(w_chain[k] & taps)};
            assign w_bits[k] = (w_n > c_K) & w_chain[k+1][0];
        end
    endgenerate

    always_comb begin
        w_next = w_chain[0];
        for (int i = 1; i <= MAX_STEP; i++) begin
            if (w_n == SC_W'(i)) begin
                w_next = w_chain[i];
            end
        end
    end

    // One extra bit catches the carry so the counter can saturate instead of wrap.
    assign w_sum      = {1'b0, r_cnt} + (CNT_W + 1)'(w_n);
    assign w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    assign w_recover  = (AUTO_RECOVER != 0) && (r_state == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_STATE;
            r_seed  <= RESET_STATE;
            r_bits  <= '0;
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            if (reinit) begin
                r_state <= initial_state;
                r_seed  <= initial_state;
                r_cnt   <= '0;
            end else if (advance) begin
                r_valid <= 1'b1;
                if (w_recover) begin
                    r_state <= c_RECOVER;
                    r_bits  <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_next;
                    r_bits  <= w_bits;
                    r_cnt   <= w_cnt_next;
                    r_hit   <= (w_n != '0) && (w_next == r_seed);
                end
            end
        end
    end

    assign out_state = r_state;
    assign out_bits  = r_bits;
    assign out_valid = r_valid;
    assign lockup    = (r_state == '0);
    assign seed_hit  = r_hit;
    assign step_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_multistep.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_multistep
// Description : Self-checking bench for lfsr_multistep (WIDTH=5, MAX_STEP=4,
//               AUTO_RECOVER=1, CNT_W=6) with a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_multistep;

    localparam int WIDTH = 5;
    localparam int MAXS  = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = 63;
    localparam int AR    = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             reinit = 1'b0;
    logic             advance = 1'b0;
    logic [2:0]       step_count = 3'd1;
    logic             galois = 1'b0;
    logic [WIDTH-1:0] initial_state = '0;
    logic [WIDTH-1:0] taps = 5'b10100;
    logic [WIDTH-1:0] out_state;
    logic [MAXS-1:0]  out_bits;
    logic             out_valid;
    logic             lockup;
    logic             seed_hit;
    logic [CNT_W-1:0] step_cnt;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_multistep #(
        .WIDTH(WIDTH), .MAX_STEP(MAXS), .RESET_STATE(5'd1),
        .AUTO_RECOVER(AR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
        .step_count(step_count), .galois(galois), .initial_state(initial_state),
        .taps(taps), .out_state(out_state), .out_bits(out_bits),
        .out_valid(out_valid), .lockup(lockup), .seed_hit(seed_hit),
        .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: LFSR steps as integer arithmetic on a 5-bit value.
    function automatic int f_clamp(input int sc);
        return (sc > MAXS) ? MAXS : sc;
    endfunction

    function automatic int f_step(input int s, input int t, input bit gal);
        if (!gal) return ((s * 2) % 32) + ($countones(s & t) % 2);
        return ((s * 2) % 32) ^ ((s >= 16) ? t : 0);
    endfunction

    function automatic int f_walk(input int s, input int n, input int t, input bit gal);
        int x = s;
        for (int i = 0; i < n; i++) x = f_step(x, t, gal);
        return x;
    endfunction

    function automatic int f_bits(input int s, input int n, input int t, input bit gal);
        int x = s;
        int b = 0;
        for (int i = 0; i < n; i++) begin
            x = f_step(x, t, gal);
            b += (x % 2) << i;
        end
        return b;
    endfunction

    int m_state, m_seed, m_bits, m_cnt;
    bit m_valid, m_hit;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 1; m_seed <= 1; m_bits <= 0;
            m_valid <= 0; m_hit <= 0; m_cnt <= 0;
        end else begin
            m_valid <= 0;
            m_hit   <= 0;
            if (reinit) begin
                m_state <= int'(initial_state);
                m_seed  <= int'(initial_state);
                m_cnt   <= 0;
            end else if (advance) begin
                m_valid <= 1;
                if (AR != 0 && m_state == 0) begin
                    m_state <= 1; m_cnt <= 0; m_bits <= 0;
                end else begin
                    m_state <= f_walk(m_state, f_clamp(int'(step_count)), int'(taps), galois);
                    m_bits  <= f_bits(m_state, f_clamp(int'(step_count)), int'(taps), galois);
                    m_hit   <= (f_clamp(int'(step_count)) > 0) &&
                               (f_walk(m_state, f_clamp(int'(step_count)), int'(taps), galois) == m_seed);
                    m_cnt   <= (m_cnt + f_clamp(int'(step_count)) > CMAX) ? CMAX
                               : m_cnt + f_clamp(int'(step_count));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_state",  out_state, m_state);
            chk("m_valid",  out_valid, m_valid);
            chk("m_hit",    seed_hit,  m_hit);
            chk("m_cnt",    step_cnt,  m_cnt);
            chk("m_lockup", lockup,    m_state == 0);
            if (m_valid) chk("m_bits", out_bits, m_bits);
        end
    end

    task automatic do_reinit(input logic [WIDTH-1:0] seed);
        @(negedge clk);
        reinit = 1'b1;
        initial_state = seed;
        @(negedge clk);
        reinit = 1'b0;
    endtask

    task automatic do_adv(input logic [2:0] n);
        @(negedge clk);
        advance = 1'b1;
        step_count = n;
        @(negedge clk);
        advance = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;
        #1 rst = 1'b1;
        #2;
        chk("rst_state", out_state, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_lockup", lockup, 0);
        chk("rst_cnt", step_cnt, 0);
        chk("rst_bits", out_bits, 0);
        chk("rst_hit", seed_hit, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: three single Fibonacci steps
        do_reinit(5'b00001);
        do_adv(3'd1);
        chk("t1_s1", out_state, 5'b00010); chk("t1_b1", out_bits[0], 0);
        do_adv(3'd1);
        chk("t1_s2", out_state, 5'b00100); chk("t1_b2", out_bits[0], 0);
        do_adv(3'd1);
        chk("t1_s3", out_state, 5'b01001); chk("t1_b3", out_bits[0], 1);
        chk("t1_cnt", step_cnt, 3);

        // T2: one three-step advance
        do_reinit(5'b00001);
        do_adv(3'd3);
        chk("t2_state", out_state, 5'b01001);
        chk("t2_bits", out_bits, 4'b0100);
        chk("t2_valid", out_valid, 1);
        chk("t2_cnt", step_cnt, 3);
        @(negedge clk);
        chk("t2_valid_drop", out_valid, 0);

        // T3: full period, seed_hit only at the end
        do_reinit(5'b00001);
        hits = 0;
        for (int i = 0; i < 31; i++) begin
            do_adv(3'd1);
            chk("t3_hit", seed_hit, (i == 30) ? 1 : 0);
            chk("t3_lockup", lockup, 0);
            hits += int'(seed_hit);
        end
        chk("t3_hits", hits, 1);
        chk("t3_cnt", step_cnt, 31);

        // Saturation: 31 + 16*4 exceeds 63
        for (int i = 0; i < 16; i++) do_adv(3'd4);
        chk("sat_cnt", step_cnt, 63);

        // Clamp: step_count=7 behaves as 4 steps
        do_reinit(5'b00001);
        do_adv(3'd7);
        chk("clamp_state", out_state, 5'b10010);
        chk("clamp_bits", out_bits, 4'b0100);
        chk("clamp_cnt", step_cnt, 4);

        // n=0: state and counter hold, valid still pulses
        do_adv(3'd0);
        chk("n0_state", out_state, 5'b10010);
        chk("n0_valid", out_valid, 1);
        chk("n0_bits", out_bits, 0);
        chk("n0_cnt", step_cnt, 4);

        // T4: lock-up and auto recovery
        do_reinit(5'b00000);
        chk("t4_lockup", lockup, 1);
        do_adv(3'd1);
        chk("t4_state", out_state, 1);
        chk("t4_lockup_clr", lockup, 0);
        chk("t4_valid", out_valid, 1);
        chk("t4_cnt", step_cnt, 0);
        chk("t4_hit", seed_hit, 0);

        // T5: reinit wins over advance, then async reset mid-stream
        @(negedge clk);
        reinit = 1'b1; advance = 1'b1; step_count = 3'd1; initial_state = 5'b10101;
        @(negedge clk);
        reinit = 1'b0; advance = 1'b0;
        chk("t5_state", out_state, 5'b10101);
        chk("t5_valid", out_valid, 0);
        chk("t5_cnt", step_cnt, 0);
        do_adv(3'd2);
        chk("t5_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_state", out_state, 1);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_cnt", step_cnt, 0);
        chk("t5_rst_bits", out_bits, 0);
        chk("t5_rst_lockup", lockup, 0);
        @(negedge clk);
        rst = 1'b0;

        // T6: Galois mode, then a clamped Galois advance
        galois = 1'b1;
        taps = 5'b00101;
        do_reinit(5'b10000);
        do_adv(3'd1);
        chk("t6_state", out_state, 5'b00101);
        chk("t6_bits", out_bits, 4'b0001);
        do_adv(3'd7);
        chk("t6_clamp_state", out_state, 5'b11010);
        chk("t6_clamp_bits", out_bits, 4'b0100);
        chk("t6_cnt", step_cnt, 5);

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
